// File: rtl/neuron_mac_stage.sv
// Per-neuron MAC: steps weight address per accepted beat, accumulates products, adds bias, rescales, saturates.
// Result valid three cycles after the last beat's handshake cycle; held with in_ready low until out_ready.
module neuron_mac_stage #(
  parameter int numWeight      = 3,
  parameter int addressWidth   = 10,
  parameter int dataWidth      = 16,
  parameter int fracWidth      = 8,
  parameter int input_channels = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [input_channels*dataWidth-1:0]    in_data,
  output logic [addressWidth-1:0]                radd,
  input  logic [input_channels*dataWidth-1:0]    wout,
  input  logic [dataWidth-1:0]                   bias,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [dataWidth-1:0]                   out_data,
  output logic                                   busy
);

  localparam int BEATS = numWeight / input_channels;
  localparam int ACCW  = 2*dataWidth + $clog2(numWeight) + 1;
  localparam int SUMW  = ACCW + 1;
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(BEATS - 1);

  typedef enum logic [1:0] {ACC, FLUSH, RESULT} state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] radd_q, radd_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [ACCW-1:0]  prod_q, prod_d;
  logic                    prod_vld_q, prod_vld_d;
  logic                    out_valid_q, out_valid_d;
  logic [dataWidth-1:0]    out_data_q, out_data_d;

  logic                    accept;
  logic signed [SUMW-1:0]  sum;
  logic signed [SUMW-1:0]  scaled;
  logic                    fits;
  logic [dataWidth-1:0]    sat_res;

  function automatic logic signed [ACCW-1:0] dot(
    input logic [input_channels*dataWidth-1:0] x,
    input logic [input_channels*dataWidth-1:0] w
  );
    logic signed [ACCW-1:0]        s;
    logic signed [dataWidth-1:0]   xa;
    logic signed [dataWidth-1:0]   wa;
    logic signed [2*dataWidth-1:0] p;
    s = '0;
    for (int i = 0; i < input_channels; i++) begin
      xa = x[i*dataWidth +: dataWidth];
      wa = w[i*dataWidth +: dataWidth];
      p  = xa * wa;
      s  = s + {{(ACCW-2*dataWidth){p[2*dataWidth-1]}}, p};
    end
    return s;
  endfunction

  assign accept = in_valid && (state_q == ACC);

  // Bias is aligned to the product's Q format before the single rescaling shift.
  assign sum     = {acc_q[ACCW-1], acc_q}
                 + ({{(SUMW-dataWidth){bias[dataWidth-1]}}, bias} <<< fracWidth);
  assign scaled  = sum >>> fracWidth;
  assign fits    = (scaled[SUMW-1:dataWidth-1] == {(SUMW-dataWidth+1){scaled[SUMW-1]}});
  assign sat_res = fits            ? scaled[dataWidth-1:0] :
                   scaled[SUMW-1]  ? {1'b1, {(dataWidth-1){1'b0}}} :
                                     {1'b0, {(dataWidth-1){1'b1}}};

  always_comb begin
    state_d     = state_q;
    radd_d      = radd_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    acc_d       = prod_vld_q ? (acc_q + prod_q) : acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          prod_d     = dot(in_data, wout);
          prod_vld_d = 1'b1;
          if (radd_q == LAST_ADDR) begin
            radd_d  = '0;
            state_d = FLUSH;
          end else begin
            radd_d  = radd_q + addressWidth'(1);
          end
        end
      end
      FLUSH: begin
        // Wait one cycle while the last product drains into the accumulator.
        if (!prod_vld_q) begin
          out_data_d  = sat_res;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      radd_q      <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      radd_q      <= radd_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign radd      = radd_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ACC) || (radd_q != '0);

endmodule

// File: tb/tb_neuron_mac_stage.sv
// Directed bench for neuron_mac_stage: single-channel and three-channel instances sharing one reset.
module tb_neuron_mac_stage;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [DW-1:0] in_data1, wout1, bias1, out_data1;
  logic [9:0]    radd1;

  logic            in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [3*DW-1:0] in_data3, wout3;
  logic [DW-1:0]   bias3, out_data3;
  logic [9:0]      radd3;

  logic [DW-1:0]   mem1 [0:2];
  logic [3*DW-1:0] mem3;

  int n_cmp = 0;
  int n_err = 0;

  neuron_mac_stage #(.numWeight(3), .addressWidth(10), .dataWidth(DW), .fracWidth(8),
                     .input_channels(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .radd(radd1), .wout(wout1), .bias(bias1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1));

  neuron_mac_stage #(.numWeight(3), .addressWidth(10), .dataWidth(DW), .fracWidth(8),
                     .input_channels(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .radd(radd3), .wout(wout3), .bias(bias3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .busy(busy3));

  always_comb begin
    wout1 = '0;
    case (radd1)
      10'd0:   wout1 = mem1[0];
      10'd1:   wout1 = mem1[1];
      10'd2:   wout1 = mem1[2];
      default: wout1 = '0;
    endcase
  end
  assign wout3 = (radd3 == 10'd0) ? mem3 : '0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input int w0, input int w1, input int w2, input int b);
    mem1[0] = DW'(w0);
    mem1[1] = DW'(w1);
    mem1[2] = DW'(w2);
    bias1   = DW'(b);
  endtask

  task automatic beat1(input int x);
    int n = 0;
    in_valid1 = 1'b1;
    in_data1  = DW'(x);
    while (!in_ready1 && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready1) check("beat_accept_timeout", 0, 1);
    tick();
    in_valid1 = 1'b0;
  endtask

  task automatic wait_out1(input string tag, input int exp);
    int n = 0;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_data"}, $signed(out_data1), exp);
  endtask

  task automatic release1(input string tag);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check({tag, "_vld_drop"}, int'(out_valid1), 0);
    check({tag, "_in_rdy"}, int'(in_ready1), 1);
    check({tag, "_idle"}, int'(busy1), 0);
  endtask

  task automatic run1(input string tag, input int x0, input int x1, input int x2,
                      input int gap, input int exp, input bit rel);
    int xs[3];
    xs = '{x0, x1, x2};
    for (int k = 0; k < 3; k++) begin
      check({tag, "_radd"}, int'(radd1), k);
      beat1(xs[k]);
      if (k < 2) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check({tag, "_radd_hold"}, int'(radd1), k + 1);
        end
      end
    end
    check({tag, "_radd_wrap"}, int'(radd1), 0);
    check({tag, "_busy"}, int'(busy1), 1);
    check({tag, "_in_rdy_flush"}, int'(in_ready1), 0);
    wait_out1(tag, exp);
    if (rel) release1(tag);
  endtask

  initial begin
    int held;
    int n;
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0; bias1 = '0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0; bias3 = '0;
    mem1[0] = '0; mem1[1] = '0; mem1[2] = '0; mem3 = '0;
    #1;
    check("rst_radd", int'(radd1), 0);
    check("rst_out_valid", int'(out_valid1), 0);
    check("rst_out_data", int'(out_data1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_in_ready", int'(in_ready1), 1);
    #12 rst_n = 1'b1;
    tick();

    // T1: 65536 + 131072 - 65536 = 131072; + 128<<8 -> 163840 >> 8 = 640
    load1(256, 512, -128, 128);
    run1("t1", 256, 256, 512, 0, 640, 1'b1);

    // T2: bubbles, with out_ready held high so it is ignored until valid
    out_ready1 = 1'b1;
    run1("t2", 256, 256, 512, 2, 640, 1'b1);

    // T3: saturation at both rails
    load1(32767, 32767, 32767, 32767);
    run1("t3_pos", 32767, 32767, 32767, 0, 32767, 1'b1);
    load1(-32768, -32768, -32768, 0);
    run1("t3_neg", 32767, 32767, 32767, 0, -32768, 1'b1);

    // T4: held result under backpressure; in_valid is ignored meanwhile
    load1(256, 512, -128, 128);
    run1("t4", 256, 256, 512, 0, 640, 1'b0);
    in_valid1 = 1'b1;
    in_data1  = DW'(1000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_vld", int'(out_valid1), 1);
      check("t4_hold_data", $signed(out_data1), 640);
      check("t4_hold_in_rdy", int'(in_ready1), 0);
    end
    check("t4_hold_radd", int'(radd1), 0);
    in_valid1 = 1'b0;
    release1("t4");
    run1("t4_second", 256, 256, 512, 0, 640, 1'b1);

    // T5: three channels in one beat
    mem3      = {16'hFF80, 16'h0200, 16'h0100};
    bias3     = 16'd128;
    in_data3  = {16'h0200, 16'h0100, 16'h0100};
    check("t5_in_rdy", int'(in_ready3), 1);
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    check("t5_radd", int'(radd3), 0);
    check("t5_busy", int'(busy3), 1);
    n = 0;
    while (!out_valid3 && n < 20) begin
      tick();
      n++;
    end
    check("t5_latency", n, 2);
    check("t5_data", $signed(out_data3), 640);
    check("t5_radd_end", int'(radd3), 0);
    out_ready3 = 1'b1;
    tick();
    out_ready3 = 1'b0;
    check("t5_vld_drop", int'(out_valid3), 0);

    // T6: reset after two of three beats
    load1(256, 512, -128, 128);
    held = $signed(out_data1);
    check("t6_pre_data", held, 640);
    beat1(256);
    beat1(256);
    check("t6_pre_radd", int'(radd1), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_radd", int'(radd1), 0);
    check("t6_rst_out_valid", int'(out_valid1), 0);
    check("t6_rst_out_data", int'(out_data1), 0);
    check("t6_rst_busy", int'(busy1), 0);
    check("t6_rst_in_ready", int'(in_ready1), 1);
    #3 rst_n = 1'b1;
    tick();
    run1("t6_after", 256, 256, 512, 0, 640, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
